io_scheduler: RTL and testbench

Sample-stream scheduler between the external world and the floating-point training core's integer I/O wrapper. It buffers incoming samples per input channel, serves the core's one-hot `req_in` strobes from those buffers, and captures results on `out_en` strobes into per-channel output buffers. A round-robin arbiter merges the output buffers onto one shared output stream. It lets several producers and consumers share the core's single `io_in`/`io_out` port pair without the core stalling.

---
 rtl/io_sched_pkg.sv | 36 +++
 rtl/io_scheduler_if.sv | 46 ++++
 rtl/io_scheduler_sync_fifo.sv | 58 +++++
 rtl/io_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_io_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_sched_pkg.sv
// io_sched_pkg: shared defaults and helpers for the io_scheduler slice.
// Contents: default channel counts/widths, channel-index width function,
// round-robin next-grant search used by the drain arbiter.
// Optional build feature: IOSCHED_ERRCNT_EN (see io_scheduler.sv).
package io_sched_pkg;

  localparam int unsigned NUIOIN_DEF = 4;
  localparam int unsigned NUIOOU_DEF = 4;
  localparam int unsigned NBIN_DEF   = 13;
  localparam int unsigned NBOUT_DEF  = 21;
  localparam int unsigned FDEPTH_DEF = 4;
  localparam int unsigned ERRCNT_W   = 16;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set bit of req searching upward from ptr, wrapping at n.
  // Scans the farthest offset first so the nearest hit is the last write.
  // Returns ptr when req is empty; the caller qualifies with |req.
  function automatic int rr_grant(input logic [31:0] req, input int ptr, input int n);
    int idx;
    int res;
    res = ptr;
    for (int i = 31; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/io_scheduler_if.sv
// io_scheduler_if: bundle of the external input stream, the core I/O
// strobes, the shared output stream and the error flag signals.
// Modports: slave = scheduler side, master = environment side.
interface io_scheduler_if
  import io_sched_pkg::*;
#(
  parameter int unsigned NUIOIN = NUIOIN_DEF,
  parameter int unsigned NUIOOU = NUIOOU_DEF,
  parameter int unsigned NBIN   = NBIN_DEF,
  parameter int unsigned NBOUT  = NBOUT_DEF
);

  localparam int unsigned CIW = ch_w(NUIOIN);
  localparam int unsigned COW = ch_w(NUIOOU);

  // external input stream
  logic              ext_valid;
  logic [CIW-1:0]    ext_ch;
  logic [NBIN-1:0]   ext_data;
  logic              ext_ready;
  // core side
  logic [NUIOIN-1:0] req_in;
  logic [NBIN-1:0]   io_in;
  logic [NUIOOU-1:0] out_en;
  logic [NBOUT-1:0]  io_out;
  // shared output stream
  logic              out_valid;
  logic              out_ready;
  logic [COW-1:0]    out_ch;
  logic [NBOUT-1:0]  out_data;
  // error flags
  logic [NUIOIN-1:0] err_udf;
  logic [NUIOOU-1:0] err_ovf;
  logic              err_clr;

  modport slave (
    input  ext_valid, ext_ch, ext_data, req_in, out_en, io_out, out_ready, err_clr,
    output ext_ready, io_in, out_valid, out_ch, out_data, err_udf, err_ovf
  );

  modport master (
    output ext_valid, ext_ch, ext_data, req_in, out_en, io_out, out_ready, err_clr,
    input  ext_ready, io_in, out_valid, out_ch, out_data, err_udf, err_ovf
  );

endinterface

// File: rtl/io_scheduler_sync_fifo.sv
// sync_fifo: single-clock FIFO with count-based full/empty.
// Ports: clk, rst (sync, active-low), push/din, pop, head_c (current head,
// combinational), full_c/empty_c (combinational status).
// A pop of an empty FIFO is ignored; a push to a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // status and qualified strobes
  always_comb begin
    empty_c = (count == '0);
    full_c  = (count == CW'(DEPTH));
    do_pop  = pop && !empty_c;
    do_push = push && (!full_c || do_pop);
  end

  assign head_c = mem[rd_ptr];

  // storage array; no reset needed, validity comes from count
  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/io_scheduler.sv
// io_scheduler: buffers external samples per input channel for the core's
// one-hot req_in reads, captures core results on out_en into per-channel
// output buffers, and drains them round-robin onto one output stream.
// Ports: clk, rst (sync, active-low), bus (io_scheduler_if.slave).
// Optional: IOSCHED_ERRCNT_EN adds err_cnt[15:0], a saturating count of
// cycles with at least one underflow/overflow event.
module io_scheduler
  import io_sched_pkg::*;
#(
  parameter int unsigned NUIOIN = NUIOIN_DEF,
  parameter int unsigned NUIOOU = NUIOOU_DEF,
  parameter int unsigned NBIN   = NBIN_DEF,
  parameter int unsigned NBOUT  = NBOUT_DEF,
  parameter int unsigned FDEPTH = FDEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  io_scheduler_if.slave       bus
`ifdef IOSCHED_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned CIW = ch_w(NUIOIN);
  localparam int unsigned COW = ch_w(NUIOOU);

  // input buffers
  logic [NUIOIN-1:0] in_push;
  logic [NUIOIN-1:0] in_pop;
  logic [NUIOIN-1:0] in_full;
  logic [NUIOIN-1:0] in_empty;
  logic [NBIN-1:0]   in_head [NUIOIN];

  // output buffers
  logic [NUIOOU-1:0] ou_pop;
  logic [NUIOOU-1:0] ou_full;
  logic [NUIOOU-1:0] ou_empty;
  logic [NBOUT-1:0]  ou_head [NUIOOU];

  logic              ext_ready_c;
  logic              rd_hit;
  logic [CIW-1:0]    rd_sel;
  logic [NBIN-1:0]   io_in_c;
  logic [NUIOIN-1:0] udf_set;
  logic [NUIOOU-1:0] ovf_set;

  logic              drain_ld;
  logic              grant_any;
  logic [COW-1:0]    grant;

  logic              out_valid_q;
  logic [COW-1:0]    out_ch_q;
  logic [NBOUT-1:0]  out_data_q;
  logic [COW-1:0]    rr_ptr;
  logic [NUIOIN-1:0] err_udf_q;
  logic [NUIOOU-1:0] err_ovf_q;

  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    sync_fifo #(.WIDTH(NBIN), .DEPTH(FDEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_push[k]),
      .din     (bus.ext_data),
      .pop     (in_pop[k]),
      .head_c  (in_head[k]),
      .full_c  (in_full[k]),
      .empty_c (in_empty[k])
    );
  end

  for (genvar k = 0; k < NUIOOU; k++) begin : g_ou
    sync_fifo #(.WIDTH(NBOUT), .DEPTH(FDEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (bus.out_en[k]),
      .din     (bus.io_out),
      .pop     (ou_pop[k]),
      .head_c  (ou_head[k]),
      .full_c  (ou_full[k]),
      .empty_c (ou_empty[k])
    );
  end

  // external push decode; ready reflects only the current fill state
  always_comb begin
    ext_ready_c = 1'b0;
    in_push     = '0;
    if (32'(bus.ext_ch) < NUIOIN) ext_ready_c = !in_full[bus.ext_ch];
    if (bus.ext_valid && ext_ready_c) in_push[bus.ext_ch] = 1'b1;
  end

  // lowest set bit of req_in picks the channel served this cycle
  always_comb begin
    rd_hit = 1'b0;
    rd_sel = '0;
    for (int i = int'(NUIOIN) - 1; i >= 0; i--) begin
      if (bus.req_in[i]) begin
        rd_hit = 1'b1;
        rd_sel = CIW'(i);
      end
    end
  end

  // core read: pop the head, or flag underflow on an empty buffer
  always_comb begin
    in_pop  = '0;
    udf_set = '0;
    io_in_c = '0;
    if (rd_hit) begin
      if (in_empty[rd_sel]) begin
        udf_set[rd_sel] = 1'b1;
      end else begin
        in_pop[rd_sel] = 1'b1;
        io_in_c        = in_head[rd_sel];
      end
    end
  end

  // drain arbiter grant; a pop frees space for a same-cycle out_en push
  always_comb begin
    ou_pop    = '0;
    drain_ld  = !out_valid_q || bus.out_ready;
    grant_any = !(&ou_empty);
    grant     = COW'(rr_grant(32'(~ou_empty), int'(rr_ptr), int'(NUIOOU)));
    if (drain_ld && grant_any) ou_pop[grant] = 1'b1;
    ovf_set = bus.out_en & ou_full & ~ou_pop;
  end

  // output register, round-robin pointer and sticky flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      rr_ptr      <= '0;
      err_udf_q   <= '0;
      err_ovf_q   <= '0;
    end else begin
      if (drain_ld) begin
        if (grant_any) begin
          out_valid_q <= 1'b1;
          out_ch_q    <= grant;
          out_data_q  <= ou_head[grant];
          rr_ptr      <= (32'(grant) == NUIOOU - 1) ? '0 : grant + COW'(1);
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      // a set event in the clearing cycle survives the clear
      err_udf_q <= (bus.err_clr ? '0 : err_udf_q) | udf_set;
      err_ovf_q <= (bus.err_clr ? '0 : err_ovf_q) | ovf_set;
    end
  end

  assign bus.ext_ready = ext_ready_c;
  assign bus.io_in     = io_in_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.err_udf   = err_udf_q;
  assign bus.err_ovf   = err_ovf_q;

`ifdef IOSCHED_ERRCNT_EN
  logic                any_evt;
  logic [ERRCNT_W-1:0] err_cnt_q;

  assign any_evt = (|udf_set) || (|ovf_set);

  // one count per cycle with any event, saturating
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= any_evt ? ERRCNT_W'(1) : '0;
    end else if (any_evt && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_io_scheduler.sv
// tb_io_scheduler: directed self-checking bench for io_scheduler.
// Covers reset state, buffered reads, underflow and clear, same-cycle
// push/underflow, input full, output overflow with hold, round-robin
// drain order and reset mid-stream. Checks err_cnt when
// IOSCHED_ERRCNT_EN is defined.
module tb_io_scheduler;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  io_scheduler_if bus ();

`ifdef IOSCHED_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  io_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IOSCHED_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef IOSCHED_ERRCNT_EN
    check(tag, 32'(err_cnt), 32'(exp));
`endif
  endtask

  initial begin
    logic [31:0] rr_ch   [4];
    logic [31:0] rr_data [4];
    total = 0;
    bad   = 0;
    rr_ch   = '{32'd1, 32'd2, 32'd3, 32'd0};
    rr_data = '{32'd20, 32'd30, 32'd40, 32'd50};

    rst           = 1'b0;
    bus.ext_valid = 1'b0;
    bus.ext_ch    = '0;
    bus.ext_data  = '0;
    bus.req_in    = '0;
    bus.out_en    = '0;
    bus.io_out    = '0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_ch",    32'(bus.out_ch),    32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_err_udf",   32'(bus.err_udf),   32'd0);
    check("rst_err_ovf",   32'(bus.err_ovf),   32'd0);
    check("rst_ext_ready", 32'(bus.ext_ready), 32'd1);
    check("rst_io_in",     32'(bus.io_in),     32'd0);
    check_cnt("rst_err_cnt", 16'd0);
    rst = 1'b1;
    tick();

    // buffered read on ch2: 100 then -5
    bus.ext_valid = 1'b1;
    bus.ext_ch    = 2'd2;
    bus.ext_data  = 13'd100;
    tick();
    bus.ext_data  = 13'h1FFB;
    tick();
    bus.ext_valid = 1'b0;
    bus.req_in    = 4'b0100;
    #1;
    check("rd_first", 32'(bus.io_in), 32'd100);
    tick();
    check("rd_second", 32'(bus.io_in), 32'h1FFB);
    tick();
    bus.req_in = 4'b0000;
    #1;
    check("rd_idle_io_in", 32'(bus.io_in), 32'd0);
    check("rd_no_udf", 32'(bus.err_udf), 32'd0);

    // underflow ch0 with multi-bit request; only lowest bit served
    bus.req_in = 4'b0101;
    #1;
    check("udf_io_in", 32'(bus.io_in), 32'd0);
    tick();
    bus.req_in = 4'b0000;
    check("udf_flag0", 32'(bus.err_udf), 32'b0001);
    check_cnt("udf_cnt1", 16'd1);
    // ch2 was drained above
    bus.req_in = 4'b0100;
    #1;
    check("udf_ch2_io_in", 32'(bus.io_in), 32'd0);
    tick();
    bus.req_in = 4'b0000;
    check("udf_flag02", 32'(bus.err_udf), 32'b0101);
    check_cnt("udf_cnt2", 16'd2);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("clr_udf", 32'(bus.err_udf), 32'd0);
    check_cnt("clr_cnt", 16'd0);
    // event in the clearing cycle wins
    bus.err_clr = 1'b1;
    bus.req_in  = 4'b0001;
    tick();
    bus.err_clr = 1'b0;
    bus.req_in  = 4'b0000;
    check("clr_set_wins", 32'(bus.err_udf), 32'b0001);
    check_cnt("clr_set_cnt", 16'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // same-cycle push and pop on empty ch3: underflow, data still stored
    bus.ext_valid = 1'b1;
    bus.ext_ch    = 2'd3;
    bus.ext_data  = 13'd777;
    bus.req_in    = 4'b1000;
    #1;
    check("pp_io_in", 32'(bus.io_in), 32'd0);
    tick();
    bus.ext_valid = 1'b0;
    check("pp_udf", 32'(bus.err_udf), 32'b1000);
    check("pp_stored", 32'(bus.io_in), 32'd777);
    tick();
    bus.req_in = 4'b0000;
    check("pp_no_extra_udf", 32'(bus.err_udf), 32'b1000);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // fill ch1
    bus.ext_valid = 1'b1;
    bus.ext_ch    = 2'd1;
    for (int i = 1; i <= 4; i++) begin
      bus.ext_data = 13'(i);
      tick();
    end
    bus.ext_valid = 1'b0;
    #1;
    check("full_ch1_ready", 32'(bus.ext_ready), 32'd0);
    bus.ext_ch = 2'd0;
    #1;
    check("full_ch0_ready", 32'(bus.ext_ready), 32'd1);
    bus.ext_ch    = 2'd1;
    bus.ext_valid = 1'b1;
    bus.ext_data  = 13'd99;
    tick();
    bus.ext_valid = 1'b0;
    bus.req_in    = 4'b0010;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("full_order", 32'(bus.io_in), 32'(i));
      tick();
    end
    bus.req_in = 4'b0000;
    #1;
    check("full_drained_ready", 32'(bus.ext_ready), 32'd1);
    check("full_no_udf", 32'(bus.err_udf), 32'd0);

    // output overflow on ch3 with out_ready low
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      bus.out_en = 4'b1000;
      bus.io_out = 21'(1000 + i);
      tick();
      if (i == 1) check("ovf_lat0", 32'(bus.out_valid), 32'd0);
      if (i == 2) begin
        check("ovf_lat1", 32'(bus.out_valid), 32'd1);
        check("ovf_ch", 32'(bus.out_ch), 32'd3);
      end
      if (i == 5) check("ovf_none_yet", 32'(bus.err_ovf), 32'd0);
      if (i == 6) begin
        check("ovf_flag", 32'(bus.err_ovf), 32'b1000);
        check("ovf_hold", 32'(bus.out_data), 32'd1001);
        check_cnt("ovf_cnt", 16'd1);
      end
    end
    bus.out_en    = 4'b0000;
    bus.out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("ovf_drain_valid", 32'(bus.out_valid), 32'd1);
      check("ovf_drain_data", 32'(bus.out_data), 32'(1000 + i));
    end
    tick();
    check("ovf_drain_empty", 32'(bus.out_valid), 32'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("ovf_clr", 32'(bus.err_ovf), 32'd0);

    // round-robin drain: load all channels plus a second ch0 word
    bus.out_ready = 1'b0;
    bus.out_en = 4'b0001; bus.io_out = 21'd10; tick();
    bus.out_en = 4'b0010; bus.io_out = 21'd20; tick();
    bus.out_en = 4'b0100; bus.io_out = 21'd30; tick();
    bus.out_en = 4'b1000; bus.io_out = 21'd40; tick();
    bus.out_en = 4'b0001; bus.io_out = 21'd50; tick();
    bus.out_en = 4'b0000;
    check("rr_first_ch", 32'(bus.out_ch), 32'd0);
    check("rr_first_data", 32'(bus.out_data), 32'd10);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_ch", 32'(bus.out_ch), rr_ch[i]);
      check("rr_data", 32'(bus.out_data), rr_data[i]);
    end
    tick();
    check("rr_empty", 32'(bus.out_valid), 32'd0);

    // reset mid-stream
    bus.out_ready = 1'b0;
    bus.ext_valid = 1'b1;
    bus.ext_ch    = 2'd0;
    bus.ext_data  = 13'd7;
    bus.out_en    = 4'b0001;
    bus.io_out    = 21'd11;
    tick();
    bus.ext_valid = 1'b0;
    bus.io_out    = 21'd12;
    tick();
    bus.out_en = 4'b0000;
    bus.req_in = 4'b0010;
    tick();
    bus.req_in = 4'b0000;
    check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    check("mid_pre_udf", 32'(bus.err_udf), 32'b0010);
    rst = 1'b0;
    tick();
    check("mid_valid", 32'(bus.out_valid), 32'd0);
    check("mid_data", 32'(bus.out_data), 32'd0);
    check("mid_ch", 32'(bus.out_ch), 32'd0);
    check("mid_udf", 32'(bus.err_udf), 32'd0);
    check("mid_ovf", 32'(bus.err_ovf), 32'd0);
    check_cnt("mid_cnt", 16'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("mid_ou_empty", 32'(bus.out_valid), 32'd0);
    bus.req_in = 4'b0001;
    #1;
    check("mid_in_empty", 32'(bus.io_in), 32'd0);
    bus.req_in = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
